// File: rtl/freq_table_builder.sv
// -----------------------------------------------------------------------------
// freq_table_builder
//
// Histograms one block of 8-bit symbols, then streams the cumulative-frequency
// table (256 x {cum_high[15:0], cum_low[15:0]}) out to SRAM for nac_sram.
// Every symbol's frequency is its count + 1, so no symbol ever has a zero
// range and every symbol stays encodable.
//
// Ports
//   clk_i          system clock
//   reset_n_i      asynchronous active-low reset
//   blk_start_i    pulse: begin a new block (honoured only in IDLE)
//   blk_end_i      pulse: last symbol presented (honoured only in COUNT)
//   sym_i          input symbol
//   sym_vld_i      sym_i valid
//   sym_rdy_o      high in COUNT; symbol taken when sym_vld_i & sym_rdy_o
//   mem_stall_i    SRAM busy; current write is held and not accepted
//   mem_wr_en_o    SRAM write strobe
//   mem_addr_o     SRAM address (symbol index)
//   mem_wr_data_o  {cum_high, cum_low}
//   busy_o         high in every state except IDLE
//   table_done_o   one-cycle pulse once the table is complete
//   total_o        cum_high of entry 255, valid from table_done_o until next start
//   ovf_o          symbols were dropped this block (sticky until next start)
// -----------------------------------------------------------------------------
module freq_table_builder #(
    parameter int unsigned MAX_SYMS = 65279,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        blk_start_i,
    input  logic        blk_end_i,
    input  logic [7:0]  sym_i,
    input  logic        sym_vld_i,
    output logic        sym_rdy_o,
    input  logic        mem_stall_i,
    output logic        mem_wr_en_o,
    output logic [7:0]  mem_addr_o,
    output logic [31:0] mem_wr_data_o,
    output logic        busy_o,
    output logic        table_done_o,
    output logic [15:0] total_o,
    output logic        ovf_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COUNT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [15:0] MAX_Q = 16'(MAX_SYMS);

    state_t             state_q, state_d;
    // Shared index: counter being cleared in CLEAR, table address in WRITE.
    logic [7:0]         idx_q, idx_d;
    logic [15:0]        acc_q, acc_d;
    logic [15:0]        tally_q, tally_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        total_q, total_d;
    logic [CNT_W-1:0]   cnt_q [256];

    logic               sym_take;
    logic               count_en;
    logic [15:0]        cum_high;

    assign sym_take = (state_q == S_COUNT) && sym_vld_i;
    // Once MAX_SYMS symbols are counted, further symbols are accepted but dropped.
    assign count_en = sym_take && (tally_q < MAX_Q);
    assign cum_high = acc_q + 16'(cnt_q[idx_q]) + 16'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        tally_d = tally_q;
        ovf_d   = ovf_q;
        total_d = total_q;

        unique case (state_q)
            S_IDLE: begin
                if (blk_start_i) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                    acc_d   = '0;
                    tally_d = '0;
                    ovf_d   = 1'b0;
                    total_d = '0;
                end
            end
            S_CLEAR: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hFF) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (count_en) begin
                    tally_d = tally_q + 16'd1;
                end else if (sym_take) begin
                    ovf_d = 1'b1;
                end
                if (blk_end_i) begin
                    state_d = S_WRITE;
                    idx_d   = '0;
                    acc_d   = '0;
                end
            end
            S_WRITE: begin
                if (!mem_stall_i) begin
                    acc_d = cum_high;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == 8'hFF) begin
                        total_d = cum_high;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            tally_q <= '0;
            ovf_q   <= 1'b0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            tally_q <= tally_d;
            ovf_q   <= ovf_d;
            total_q <= total_d;
        end
    end

    // Per-symbol counters: one cleared per CLEAR cycle, one bumped per counted
    // symbol. A read-modify-write every cycle keeps back-to-back repeats exact.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '{default: '0};
        end else if (state_q == S_CLEAR) begin
            cnt_q[idx_q] <= '0;
        end else if (count_en) begin
            cnt_q[sym_i] <= cnt_q[sym_i] + CNT_W'(1);
        end
    end

    always_comb begin
        sym_rdy_o     = (state_q == S_COUNT);
        mem_wr_en_o   = (state_q == S_WRITE);
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
        if (state_q == S_WRITE) begin
            mem_addr_o    = idx_q;
            mem_wr_data_o = {cum_high, acc_q};
        end
        busy_o       = (state_q != S_IDLE);
        table_done_o = (state_q == S_DONE);
        total_o      = total_q;
        ovf_o        = ovf_q;
    end

endmodule

// File: tb/tb_freq_table_builder.sv
module tb_freq_table_builder;

    localparam int unsigned CAP0 = 65279;
    localparam int unsigned CAP1 = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        blk_start = 1'b0;
    logic        blk_end = 1'b0;
    logic        sym_vld = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  sym = '0;

    logic [1:0]  rdy, wr_en, busy, tdone, ovf;
    logic [7:0]  maddr [2];
    logic [31:0] mdata [2];
    logic [15:0] total [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int end_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    freq_table_builder u_dut (
        .clk_i(clk), .reset_n_i(reset_n), .blk_start_i(blk_start), .blk_end_i(blk_end),
        .sym_i(sym), .sym_vld_i(sym_vld), .sym_rdy_o(rdy[0]), .mem_stall_i(stall),
        .mem_wr_en_o(wr_en[0]), .mem_addr_o(maddr[0]), .mem_wr_data_o(mdata[0]),
        .busy_o(busy[0]), .table_done_o(tdone[0]), .total_o(total[0]), .ovf_o(ovf[0])
    );

    freq_table_builder #(.MAX_SYMS(CAP1)) u_cap (
        .clk_i(clk), .reset_n_i(reset_n), .blk_start_i(blk_start), .blk_end_i(blk_end),
        .sym_i(sym), .sym_vld_i(sym_vld), .sym_rdy_o(rdy[1]), .mem_stall_i(stall),
        .mem_wr_en_o(wr_en[1]), .mem_addr_o(maddr[1]), .mem_wr_data_o(mdata[1]),
        .busy_o(busy[1]), .table_done_o(tdone[1]), .total_o(total[1]), .ovf_o(ovf[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs(input bit k);
        return {3'b0, rdy[k], wr_en[k], maddr[k], mdata[k], busy[k], tdone[k], total[k], ovf[k]};
    endfunction

    // ---------------- write monitor ----------------
    logic        mon_clr = 1'b0;
    logic [7:0]  wr_addr [2][256];
    logic [31:0] wr_data [2][256];
    int          n_wr [2];
    int          stall_cyc [2];
    int          hold_bad [2];
    int          done_cnt [2];
    int          done_cyc [2];
    bit          prev_stall [2];
    logic [7:0]  prev_addr [2];
    logic [31:0] prev_data [2];

    always @(negedge clk) begin
        for (int kk = 0; kk < 2; kk++) begin
            automatic bit k = kk[0];
            if (mon_clr) begin
                n_wr[k]       <= 0;
                stall_cyc[k]  <= 0;
                hold_bad[k]   <= 0;
                done_cnt[k]   <= 0;
                done_cyc[k]   <= 0;
                prev_stall[k] <= 1'b0;
            end else begin
                if (prev_stall[k] && !(wr_en[k] && maddr[k] == prev_addr[k] && mdata[k] == prev_data[k]))
                    hold_bad[k] <= hold_bad[k] + 1;
                if (wr_en[k] && !stall) begin
                    if (n_wr[k] < 256) begin
                        wr_addr[k][8'(n_wr[k])] <= maddr[k];
                        wr_data[k][8'(n_wr[k])] <= mdata[k];
                    end
                    n_wr[k] <= n_wr[k] + 1;
                end
                if (wr_en[k] && stall) stall_cyc[k] <= stall_cyc[k] + 1;
                if (tdone[k]) begin
                    done_cnt[k] <= done_cnt[k] + 1;
                    done_cyc[k] <= cyc;
                end
                prev_stall[k] <= wr_en[k] && stall;
                prev_addr[k]  <= maddr[k];
                prev_data[k]  <= mdata[k];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [7:0]  blk_syms [$];
    logic [31:0] mexp [2][256];
    logic [15:0] mtotal [2];
    bit          movf [2];

    task automatic model_block();
        int unsigned cnt [256];
        int unsigned cap, n, cum;
        for (int kk = 0; kk < 2; kk++) begin
            automatic bit k = kk[0];
            cap = k ? CAP1 : CAP0;
            n = 0;
            movf[k] = 1'b0;
            foreach (cnt[s]) cnt[s] = 0;
            foreach (blk_syms[i]) begin
                if (n < cap) begin
                    cnt[blk_syms[i]]++;
                    n++;
                end else begin
                    movf[k] = 1'b1;
                end
            end
            cum = 0;
            for (int a = 0; a < 256; a++) begin
                mexp[k][8'(a)] = {16'(cum + cnt[8'(a)] + 1), 16'(cum)};
                cum += cnt[8'(a)] + 1;
            end
            mtotal[k] = 16'(cum);
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic start_block();
        int t0;
        @(posedge clk); #1;
        blk_start = 1'b1; mon_clr = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        blk_start = 1'b0; mon_clr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rdy[0]) break;
        end
        check("rdy_latency", 64'(cyc - t0), 64'd257);
        check("rdy_cap", 64'(rdy[1]), 64'd1);
        check("busy_count", 64'(busy), 64'd3);
        check("ovf_cleared", 64'(ovf), 64'd0);
        check("total_cleared", 64'({total[0], total[1]}), 64'd0);
    endtask

    task automatic send_syms(input bit gaps, input bit end_last, input bit inject);
        int n;
        n = blk_syms.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    @(posedge clk); #1;
                    sym_vld = 1'b0; blk_start = 1'b0; sym = 8'($urandom);
                end
            end
            @(posedge clk); #1;
            sym_vld   = 1'b1;
            sym       = blk_syms[i];
            blk_end   = end_last && (i == n - 1);
            blk_start = inject && (i == n / 2);
        end
        if (!end_last || n == 0) begin
            @(posedge clk); #1;
            sym_vld = 1'b0; blk_start = 1'b0; blk_end = 1'b1;
        end
        end_cyc = cyc;
    endtask

    // mode 0: no stall, 1: hold address 10 for 5 cycles, 2: random stalls
    task automatic write_phase(input int mode, input int abort_addr, output bit aborted);
        int left;
        left = 5;
        aborted = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            blk_end = 1'b0; sym_vld = 1'b0; blk_start = 1'b0;
            if (abort_addr >= 0 && wr_en[0] && maddr[0] == 8'(abort_addr)) begin
                reset_n = 1'b0;
                stall = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (mode == 1) begin
                if (wr_en[0] && maddr[0] == 8'd10 && left > 0) begin
                    stall = 1'b1;
                    left--;
                end else begin
                    stall = 1'b0;
                end
            end else if (mode == 2) begin
                stall = wr_en[0] && ($urandom_range(0, 3) == 0);
            end else begin
                stall = 1'b0;
            end
            @(negedge clk);
            if (tdone[0]) break;
        end
        @(posedge clk); #1;
        stall = 1'b0;
    endtask

    task automatic verify_block();
        @(negedge clk);
        for (int kk = 0; kk < 2; kk++) begin
            automatic bit k = kk[0];
            check("write_count", 64'(n_wr[k]), 64'd256);
            for (int a = 0; a < 256; a++) begin
                automatic logic [7:0] a8 = 8'(a);
                check("write_addr", 64'(wr_addr[k][a8]), 64'(a8));
                check("entry", 64'(wr_data[k][a8]), 64'(mexp[k][a8]));
            end
            check("total", 64'(total[k]), 64'(mtotal[k]));
            check("ovf", 64'(ovf[k]), 64'(movf[k]));
            check("done_pulses", 64'(done_cnt[k]), 64'd1);
            check("done_latency", 64'(done_cyc[k] - end_cyc), 64'(257 + stall_cyc[k]));
            check("stall_hold", 64'(hold_bad[k]), 64'd0);
            check("idle_after", 64'({busy[k], tdone[k], wr_en[k]}), 64'd0);
        end
    endtask

    task automatic run_block(input bit gaps, input bit end_last, input bit inject, input int mode);
        bit ab;
        model_block();
        start_block();
        send_syms(gaps, end_last, inject);
        write_phase(mode, -1, ab);
        verify_block();
    endtask

    task automatic check_t1(input string tag);
        check({tag, "_e00"}, 64'(wr_data[0][8'h00]), 64'h0001_0000);
        check({tag, "_e41"}, 64'(wr_data[0][8'h41]), 64'h0045_0041);
        check({tag, "_e42"}, 64'(wr_data[0][8'h42]), 64'h0047_0045);
        check({tag, "_eff"}, 64'(wr_data[0][8'hFF]), 64'h0104_0103);
        check({tag, "_total"}, 64'(total[0]), 64'h0104);
        check({tag, "_ovf"}, 64'(ovf[0]), 64'd0);
    endtask

    initial begin
        int t1_lat;
        int n;
        bit ab;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs0", outs(1'b0), 64'd0);
        check("reset_outs1", outs(1'b1), 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // T1
        blk_syms = '{8'h41, 8'h41, 8'h41, 8'h42};
        run_block(1'b0, 1'b1, 1'b0, 0);
        check_t1("t1");
        t1_lat = done_cyc[0] - end_cyc;

        // T2: empty block
        blk_syms = '{};
        run_block(1'b0, 1'b0, 1'b0, 0);
        check("t2_total", 64'(total[0]), 64'h0100);
        check("t2_e80", 64'(wr_data[0][8'h80]), 64'h0081_0080);

        // T3: 1000 back-to-back repeats of symbol 0
        blk_syms = '{};
        for (int i = 0; i < 1000; i++) blk_syms.push_back(8'h00);
        run_block(1'b0, 1'b0, 1'b0, 0);
        check("t3_e00", 64'(wr_data[0][8'h00]), 64'h03E9_0000);
        check("t3_e01", 64'(wr_data[0][8'h01]), 64'h03EA_03E9);
        check("t3_total", 64'(total[0]), 64'h04E8);
        check("t3_cap_ovf", 64'(ovf[1]), 64'd1);

        // T4: T1 with a 5-cycle stall at address 10
        blk_syms = '{8'h41, 8'h41, 8'h41, 8'h42};
        run_block(1'b0, 1'b1, 1'b0, 1);
        check_t1("t4");
        check("t4_stalls", 64'(stall_cyc[0]), 64'd5);
        check("t4_latency", 64'(done_cyc[0] - end_cyc), 64'(t1_lat + 5));

        // T5: cap of 4 on the second instance
        blk_syms = '{};
        for (int i = 0; i < 6; i++) blk_syms.push_back(8'h07);
        run_block(1'b0, 1'b0, 1'b0, 0);
        check("t5_e07", 64'(wr_data[1][8'h07]), 64'h000C_0007);
        check("t5_ovf", 64'(ovf[1]), 64'd1);
        check("t5_total", 64'(total[1]), 64'h0104);
        check("t5_nocap_ovf", 64'(ovf[0]), 64'd0);

        // T6: reset during WRITE at address 80, then a clean T1
        blk_syms = '{8'h41, 8'h41, 8'h41, 8'h42};
        model_block();
        start_block();
        send_syms(1'b0, 1'b1, 1'b0);
        write_phase(0, 80, ab);
        check("t6_aborted", 64'(ab), 64'd1);
        @(negedge clk);
        check("t6_outs0", outs(1'b0), 64'd0);
        check("t6_outs1", outs(1'b1), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_done", 64'({done_cnt[0], done_cnt[1]}), 64'd0);
        check("t6_idle", 64'(busy), 64'd0);
        run_block(1'b0, 1'b1, 1'b0, 0);
        check_t1("t6");

        // Randomised blocks: gaps, random stalls, late starts ignored
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 300);
            blk_syms = '{};
            for (int i = 0; i < n; i++)
                blk_syms.push_back(r[0] ? 8'($urandom_range(0, 3)) : 8'($urandom));
            run_block(1'b1, 1'($urandom_range(0, 1)), r == 2, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
